// File: rtl/crack_pkg.sv
// Shared types and default sizing for the ARC4 key-space scheduler.
package crack_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DRAIN
    } state_e;

    localparam int DEF_KEY_W      = 24;
    localparam int DEF_CHUNK_LOG2 = 12;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping around, as a one-hot vector.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    logic          hit;
    logic [PW-1:0] idx;

    always_comb begin
        grant_o = '0;
        hit     = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!hit && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                hit          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crack_scheduler.sv
// Splits the ARC4 key space into chunks, hands them round-robin to the crack
// cores, and reports the first key found or exhaustion of the space.
module crack_scheduler
    import crack_pkg::*;
#(
    parameter int NCORES     = 2,
    parameter int KEY_W      = DEF_KEY_W,
    parameter int CHUNK_LOG2 = DEF_CHUNK_LOG2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic                    rdy,
    output logic [KEY_W-1:0]        key,
    output logic                    key_valid,
    output logic [NCORES-1:0]       core_en,
    output logic [KEY_W-1:0]        core_base,
    output logic                    core_abort,
    input  logic [NCORES-1:0]       core_rdy,
    input  logic [NCORES-1:0]       core_done,
    input  logic [NCORES-1:0]       core_found,
    input  logic [NCORES*KEY_W-1:0] core_key
);

    localparam int CIDX_W = KEY_W - CHUNK_LOG2;
    localparam int CNT_W  = CIDX_W + 1;
    localparam int PW     = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = {1'b1, {CIDX_W{1'b0}}};

    state_e             state_q;
    logic [CNT_W-1:0]   chunk_q;
    logic [CNT_W-1:0]   chunk_d;
    logic [NCORES-1:0]  busy_q;
    logic [PW-1:0]      rr_q;
    logic [KEY_W-1:0]   key_q;
    logic               key_valid_q;
    logic [NCORES-1:0]  core_en_q;
    logic [KEY_W-1:0]   core_base_q;
    logic               core_abort_q;
    logic               rdy_q;

    logic               idle_start;
    logic [CNT_W-1:0]   cur_chunk;
    logic [PW-1:0]      arb_ptr;
    logic [NCORES-1:0]  req;
    logic [NCORES-1:0]  grant;
    logic [PW-1:0]      rr_next;
    logic               found_any;
    logic [KEY_W-1:0]   found_key;
    logic               take_found;
    logic               launch_ok;
    logic               launch;
    logic [KEY_W-1:0]   launch_base;

    // The start cycle itself can launch chunk 0, so it sees a cleared counter and pointer.
    assign idle_start  = (state_q == IDLE) && en;
    assign cur_chunk   = (state_q == IDLE) ? '0 : chunk_q;
    assign arb_ptr     = (state_q == IDLE) ? '0 : rr_q;
    assign req         = core_rdy & ~busy_q;
    assign take_found  = ((state_q == DISPATCH) || (state_q == DRAIN)) && found_any && !key_valid_q;
    assign launch_ok   = idle_start || ((state_q == DISPATCH) && !take_found && (chunk_q != LAST_CNT));
    assign launch      = launch_ok && (grant != '0);
    assign launch_base = {cur_chunk[CIDX_W-1:0], {CHUNK_LOG2{1'b0}}};
    assign chunk_d     = launch ? (cur_chunk + CNT_W'(1)) : (idle_start ? '0 : chunk_q);

    rr_arbiter #(
        .N  (NCORES),
        .PW (PW)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (arb_ptr),
        .grant_o (grant)
    );

    always_comb begin
        rr_next = rr_q;
        for (int i = 0; i < NCORES; i++) begin
            if (grant[i]) begin
                rr_next = PW'((i + 1) % NCORES);
            end
        end
    end

    // Descending scan so the lowest-index core wins a simultaneous find.
    always_comb begin
        found_any = 1'b0;
        found_key = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (core_done[i] && core_found[i]) begin
                found_any = 1'b1;
                found_key = core_key[i*KEY_W +: KEY_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            chunk_q      <= '0;
            busy_q       <= '0;
            rr_q         <= '0;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            core_en_q    <= '0;
            core_base_q  <= '0;
            core_abort_q <= 1'b0;
            rdy_q        <= 1'b1;
        end else begin
            core_en_q    <= launch ? grant : '0;
            core_base_q  <= launch ? launch_base : '0;
            core_abort_q <= 1'b0;
            busy_q       <= (busy_q & ~core_done) | (launch ? grant : '0);
            chunk_q      <= chunk_d;
            if (launch) begin
                rr_q <= rr_next;
            end

            case (state_q)
                IDLE: begin
                    if (en) begin
                        key_q       <= '0;
                        key_valid_q <= 1'b0;
                        rdy_q       <= 1'b0;
                        state_q     <= DISPATCH;
                        if (!launch) begin
                            rr_q <= '0;
                        end
                    end
                end
                DISPATCH: begin
                    if (take_found) begin
                        key_q        <= found_key;
                        key_valid_q  <= 1'b1;
                        core_abort_q <= 1'b1;
                        state_q      <= DRAIN;
                    end else if (chunk_d == LAST_CNT) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (take_found) begin
                        key_q        <= found_key;
                        key_valid_q  <= 1'b1;
                        core_abort_q <= 1'b1;
                    end else if (busy_q == '0) begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign rdy        = rdy_q;
    assign key        = key_q;
    assign key_valid  = key_valid_q;
    assign core_en    = core_en_q;
    assign core_base  = core_base_q;
    assign core_abort = core_abort_q;

endmodule

// File: tb/tb_crack_scheduler.sv
// Scoreboard bench for crack_scheduler with two latency-programmable core models.
module tb_crack_scheduler;

    localparam int NC = 2;
    localparam int KW = 8;
    localparam int CL = 4;

    typedef struct {
        logic [NC-1:0] en;
        logic [KW-1:0] base;
    } launch_t;

    typedef struct {
        logic          valid;
        logic [KW-1:0] key;
        int            aborts;
    } result_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             rdy;
    logic [KW-1:0]    key;
    logic             key_valid;
    logic [NC-1:0]    core_en;
    logic [KW-1:0]    core_base;
    logic             core_abort;
    logic [NC-1:0]    core_rdy;
    logic [NC-1:0]    core_done;
    logic [NC-1:0]    core_found;
    logic [NC*KW-1:0] core_key;

    int      total = 0;
    int      bad = 0;
    int      doneCount = 0;
    int      abortCount = 0;
    logic    prevRdy = 1'b1;
    launch_t expLaunch[$];
    result_t expResult[$];
    launch_t el;
    result_t er;

    int            lat[NC];
    logic [NC-1:0] stall;
    logic [NC-1:0] findEn;
    logic [KW-1:0] findBase[NC];
    logic [KW-1:0] findKey[NC];
    logic [NC-1:0] mBusy;
    logic [KW-1:0] mBase[NC];
    int            mCnt[NC];

    crack_scheduler #(
        .NCORES     (NC),
        .KEY_W      (KW),
        .CHUNK_LOG2 (CL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .rdy        (rdy),
        .key        (key),
        .key_valid  (key_valid),
        .core_en    (core_en),
        .core_base  (core_base),
        .core_abort (core_abort),
        .core_rdy   (core_rdy),
        .core_done  (core_done),
        .core_found (core_found),
        .core_key   (core_key)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Core models act on the falling edge so the DUT samples stable inputs.
    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (!rst_n) begin
                mBusy[i]      = 1'b0;
                mCnt[i]       = 0;
                core_done[i]  = 1'b0;
                core_found[i] = 1'b0;
                core_key[i*KW +: KW] = '0;
            end else begin
                core_done[i]  = 1'b0;
                core_found[i] = 1'b0;
                core_key[i*KW +: KW] = '0;
                if (mBusy[i]) begin
                    if (core_abort) begin
                        core_done[i] = 1'b1;
                        mBusy[i]     = 1'b0;
                    end else begin
                        mCnt[i] = mCnt[i] - 1;
                        if (mCnt[i] == 0) begin
                            core_done[i] = 1'b1;
                            mBusy[i]     = 1'b0;
                            if (findEn[i] && (mBase[i] == findBase[i])) begin
                                core_found[i] = 1'b1;
                                core_key[i*KW +: KW] = findKey[i];
                            end
                        end
                    end
                end
                if (core_en[i]) begin
                    mBusy[i] = 1'b1;
                    mBase[i] = core_base;
                    mCnt[i]  = lat[i];
                end
            end
            core_rdy[i] = !mBusy[i] && !stall[i];
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prevRdy = 1'b1;
        end else begin
            if (core_en != '0) begin
                checkOutput("launch_onehot", 32'($onehot(core_en)), 32'd1);
                if (expLaunch.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_launch: got core_en=%b base=0x%0h, expected no launch", core_en, core_base);
                end else begin
                    el = expLaunch.pop_front();
                    checkOutput("launch_core", 32'(core_en), 32'(el.en));
                    checkOutput("launch_base", 32'(core_base), 32'(el.base));
                end
            end
            if (core_abort) begin
                abortCount++;
                checkOutput("abort_with_key_valid", 32'(key_valid), 32'd1);
            end
            if (prevRdy && !rdy) begin
                abortCount = 0;
            end
            if (!prevRdy && rdy) begin
                doneCount++;
                if (expResult.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_done: got rdy rise, expected none");
                end else begin
                    er = expResult.pop_front();
                    checkOutput("result_key_valid", 32'(key_valid), 32'(er.valid));
                    checkOutput("result_key", 32'(key), 32'(er.key));
                    checkOutput("result_aborts", 32'(abortCount), 32'(er.aborts));
                    checkOutput("launches_left", 32'(expLaunch.size()), 32'd0);
                end
            end
            prevRdy = rdy;
        end
    end

    task automatic pushLaunch(input int core, input int chunk);
        launch_t l;
        l.en   = NC'(1 << core);
        l.base = KW'(chunk << CL);
        expLaunch.push_back(l);
    endtask

    task automatic pushResult(input logic valid, input logic [KW-1:0] k, input int aborts);
        result_t r;
        r.valid  = valid;
        r.key    = k;
        r.aborts = aborts;
        expResult.push_back(r);
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic waitDone(input string name, input int maxCycles);
        int start = doneCount;
        int n = 0;
        while ((doneCount == start) && (n < maxCycles)) begin
            @(negedge clk);
            n++;
        end
        if (doneCount == start) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: got no completion in %0d cycles, expected rdy rise", name, maxCycles);
        end
    endtask

    task automatic pushExhaust();
        for (int k = 0; k < 16; k++) begin
            pushLaunch(k % 2, k);
        end
        pushResult(1'b0, 8'h00, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        core_rdy = '1;
        core_done = '0;
        core_found = '0;
        core_key = '0;
        stall = '0;
        findEn = '0;
        lat = '{5, 5};
        findBase = '{8'h00, 8'h00};
        findKey = '{8'h00, 8'h00};
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        $display("[TB] reset then idle");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput("idle_rdy", 32'(rdy), 32'd1);
            checkOutput("idle_key_valid", 32'(key_valid), 32'd0);
            checkOutput("idle_core_en", 32'(core_en), 32'd0);
        end
        checkOutput("idle_key", 32'(key), 32'd0);
        checkOutput("idle_abort", 32'(core_abort), 32'd0);

        $display("[TB] exhaust, with a stray en mid-search");
        pushExhaust();
        applyStimulus();
        checkOutput("rdy_low_after_en", 32'(rdy), 32'd0);
        repeat (20) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        waitDone("exhaust", 600);

        $display("[TB] found mid-space on core 1");
        findEn = 2'b10;
        findBase[1] = 8'h50;
        findKey[1] = 8'h5A;
        for (int k = 0; k < 6; k++) begin
            pushLaunch(k % 2, k);
        end
        pushResult(1'b1, 8'h5A, 1);
        applyStimulus();
        waitDone("found", 600);
        repeat (5) @(negedge clk);
        checkOutput("found_key_held", 32'(key), 32'h5A);
        checkOutput("found_valid_held", 32'(key_valid), 32'd1);
        checkOutput("found_rdy", 32'(rdy), 32'd1);

        $display("[TB] simultaneous found");
        lat = '{6, 5};
        findEn = 2'b11;
        findBase = '{8'h20, 8'h30};
        findKey = '{8'h23, 8'h37};
        for (int k = 0; k < 4; k++) begin
            pushLaunch(k % 2, k);
        end
        pushResult(1'b1, 8'h23, 1);
        applyStimulus();
        checkOutput("key_valid_cleared_on_en", 32'(key_valid), 32'd0);
        checkOutput("key_cleared_on_en", 32'(key), 32'd0);
        waitDone("simultaneous", 600);

        $display("[TB] stalled core 0");
        lat = '{5, 5};
        findEn = '0;
        stall = 2'b01;
        for (int k = 0; k < 16; k++) begin
            pushLaunch(1, k);
        end
        pushResult(1'b0, 8'h00, 0);
        applyStimulus();
        waitDone("stalled", 1000);
        stall = '0;

        $display("[TB] reset mid-search");
        pushExhaust();
        applyStimulus();
        repeat (13) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_rdy", 32'(rdy), 32'd1);
        checkOutput("rst_key", 32'(key), 32'd0);
        checkOutput("rst_key_valid", 32'(key_valid), 32'd0);
        checkOutput("rst_core_en", 32'(core_en), 32'd0);
        checkOutput("rst_core_base", 32'(core_base), 32'd0);
        checkOutput("rst_core_abort", 32'(core_abort), 32'd0);
        expLaunch.delete();
        expResult.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        pushExhaust();
        applyStimulus();
        waitDone("after_reset", 600);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
